sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 16 +
 rtl/sram_arbiter_if.sv | 34 +++
 rtl/sram_arb_pick.sv | 22 ++
 rtl/sram_arbiter.sv | 140 ++++++++++++++
 tb/tb_sram_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-side signals of the arbiter; slave = arbiter, master = requesters plus SRAM.
interface sram_arbiter_if;
    import sram_arb_pkg::*;

    logic              req_a;
    logic              req_b;
    logic              we_a;
    logic              we_b;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_a;
    logic [DATA_W-1:0] wdata_b;
    logic              gnt_a;
    logic              gnt_b;
    logic              rvalid_a;
    logic              rvalid_b;
    logic [DATA_W-1:0] rdata;
    logic              mem_ce;
    logic              mem_wre;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_out;

    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_out,
        output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata, mem_ce, mem_wre, mem_addr, mem_din
    );

    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_out,
        input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata, mem_ce, mem_wre, mem_addr, mem_din
    );

endinterface

// File: rtl/sram_arb_pick.sv
// Combinational 2-way picker: a lone requester always wins, a tie goes to the owner named by ptr.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic ptr,
    output logic win,
    output logic valid
);

    always_comb begin
        valid = req_a | req_b;
        win   = OWN_A;
        if (req_a && req_b) begin
            win = ptr;
        end else if (req_b) begin
            win = OWN_B;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester SRAM arbiter with fixed grant/response latency.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise A has fixed priority over B.
module sram_arbiter
    import sram_arb_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    sram_arbiter_if.slave  bus
);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              gnt_a_q, gnt_a_d;
    logic              gnt_b_q, gnt_b_d;
    logic              rvalid_a_q, rvalid_a_d;
    logic              rvalid_b_q, rvalid_b_d;
    logic              pick_ptr;
    logic              pick_win;
    logic              pick_valid;

    sram_arb_pick u_pick (
        .req_a (bus.req_a),
        .req_b (bus.req_b),
        .ptr   (pick_ptr),
        .win   (pick_win),
        .valid (pick_valid)
    );

`ifdef SRAM_ARB_RR_EN
    logic ptr_q, ptr_d;

    assign pick_ptr = ptr_q;

    // After every grant the loser becomes the preferred requester.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && pick_valid) begin
            ptr_d = ~pick_win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= OWN_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign pick_ptr = OWN_A;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        rdata_d    = rdata_q;
        gnt_a_d    = 1'b0;
        gnt_b_d    = 1'b0;
        rvalid_a_d = 1'b0;
        rvalid_b_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_win;
                    state_d = ACCESS;
                    if (pick_win == OWN_A) begin
                        we_d       = bus.we_a;
                        mem_addr_d = bus.addr_a;
                        mem_din_d  = bus.wdata_a;
                        gnt_a_d    = 1'b1;
                    end else begin
                        we_d       = bus.we_b;
                        mem_addr_d = bus.addr_b;
                        mem_din_d  = bus.wdata_b;
                        gnt_b_d    = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdata_d = bus.mem_out;
                end
                rvalid_a_d = (owner_q == OWN_A);
                rvalid_b_d = (owner_q == OWN_B);
                state_d    = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_A;
            we_q       <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            rdata_q    <= '0;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            rdata_q    <= rdata_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
        end
    end

    // Write enable is gated by rst directly so a reset landing in ACCESS never commits.
    assign bus.mem_wre  = (state_q == ACCESS) && we_q && !rst;
    assign bus.mem_ce   = ~rst;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.rdata    = rdata_q;
    assign bus.gnt_a    = gnt_a_q;
    assign bus.gnt_b    = gnt_b_q;
    assign bus.rvalid_a = rvalid_a_q;
    assign bus.rvalid_b = rvalid_b_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: SRAM model plus transaction-level reference model.
// Expectations follow SRAM_ARB_RR_EN the same way the design does.
module tb_sram_arbiter;

`ifdef SRAM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic clk;
    logic rst;
    logic junk_en;
    int   num_checks;
    int   num_fails;

    sram_arbiter_if bus ();

    sram_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: combinational read, cleared whenever mem_ce is low at an edge.
    logic [7:0] sram [32];
    assign bus.mem_out = sram[bus.mem_addr];

    always @(posedge clk) begin
        if (junk_en) begin
            for (int i = 0; i < 32; i++) sram[i] <= 8'($urandom);
        end else if (!bus.mem_ce) begin
            for (int i = 0; i < 32; i++) sram[i] <= 8'h00;
        end else if (bus.mem_wre) begin
            sram[bus.mem_addr] <= bus.mem_din;
        end
    end

    // Reference model state.
    logic [7:0] ref_mem [32];
    logic       ref_ptr;
    logic [7:0] ref_rdata;

    task automatic modelReset();
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        ref_ptr   = 1'b0;
        ref_rdata = 8'h00;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One transaction slot: drive requests during IDLE, then check the
    // grant cycle, the response cycle and the following idle cycle.
    task automatic applyStimulus(input string tag,
                                 input bit ra, input bit wa, input logic [4:0] aa, input logic [7:0] da,
                                 input bit rb, input bit wb, input logic [4:0] ab, input logic [7:0] db);
        bit         any;
        bit         win_b;
        bit         we;
        logic [4:0] ad;
        logic [7:0] dd;
        bus.req_a   = ra;
        bus.we_a    = wa;
        bus.addr_a  = aa;
        bus.wdata_a = da;
        bus.req_b   = rb;
        bus.we_b    = wb;
        bus.addr_b  = ab;
        bus.wdata_b = db;
        any = ra || rb;
        if (ra && rb) win_b = RR_MODE ? ref_ptr : 1'b0;
        else          win_b = rb;
        if (any) ref_ptr = ~win_b;
        we = win_b ? wb : wa;
        ad = win_b ? ab : aa;
        dd = win_b ? db : da;

        @(posedge clk); #1;
        checkOutput({tag, ".gnt_a"}, 32'(bus.gnt_a), 32'(any && !win_b));
        checkOutput({tag, ".gnt_b"}, 32'(bus.gnt_b), 32'(any && win_b));
        checkOutput({tag, ".rv_g"}, 32'({bus.rvalid_a, bus.rvalid_b}), 32'(0));
        checkOutput({tag, ".mem_wre"}, 32'(bus.mem_wre), 32'(any && we));
        if (any) begin
            checkOutput({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(ad));
            if (we) checkOutput({tag, ".mem_din"}, 32'(bus.mem_din), 32'(dd));
            if (we) ref_mem[ad] = dd;
            else    ref_rdata   = ref_mem[ad];
        end

        @(posedge clk); #1;
        checkOutput({tag, ".rvalid_a"}, 32'(bus.rvalid_a), 32'(any && !win_b));
        checkOutput({tag, ".rvalid_b"}, 32'(bus.rvalid_b), 32'(any && win_b));
        checkOutput({tag, ".rdata"}, 32'(bus.rdata), 32'(ref_rdata));
        checkOutput({tag, ".gnt_r"}, 32'({bus.gnt_a, bus.gnt_b, bus.mem_wre}), 32'(0));

        @(posedge clk); #1;
        checkOutput({tag, ".quiet"}, 32'({bus.gnt_a, bus.gnt_b, bus.rvalid_a, bus.rvalid_b}), 32'(0));
    endtask

    task automatic idleInputs();
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        num_checks  = 0;
        num_fails   = 0;
        bus.req_a   = 1'b0;
        bus.req_b   = 1'b0;
        bus.we_a    = 1'b0;
        bus.we_b    = 1'b0;
        bus.addr_a  = '0;
        bus.addr_b  = '0;
        bus.wdata_a = '0;
        bus.wdata_b = '0;
        rst         = 1'b1;
        junk_en     = 1'b1;
        modelReset();

        // Fill the SRAM with garbage, then hold reset for two cycles.
        @(posedge clk); #1;
        junk_en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checkOutput("rst.mem_ce", 32'(bus.mem_ce), 32'(0));
            @(posedge clk); #1;
            checkOutput("rst.flags", 32'({bus.gnt_a, bus.gnt_b, bus.rvalid_a, bus.rvalid_b, bus.mem_wre}), 32'(0));
            checkOutput("rst.rdata", 32'(bus.rdata), 32'(0));
            checkOutput("rst.mem_addr", 32'(bus.mem_addr), 32'(0));
            checkOutput("rst.mem_din", 32'(bus.mem_din), 32'(0));
        end
        rst = 1'b0;
        #1;
        checkOutput("run.mem_ce", 32'(bus.mem_ce), 32'(1));

        applyStimulus("clr0",  1, 0, 5'd0,  8'h00, 0, 0, 5'd0, 8'h00);
        applyStimulus("clr31", 1, 0, 5'd31, 8'h00, 0, 0, 5'd0, 8'h00);

        applyStimulus("wrA3", 1, 1, 5'd3, 8'h5A, 0, 0, 5'd0, 8'h00);
        applyStimulus("rdA3", 1, 0, 5'd3, 8'h00, 0, 0, 5'd0, 8'h00);

        // A B-only grant leaves the round-robin pointer on A before the tie.
        applyStimulus("rdB7",  0, 0, 5'd0, 8'h00, 1, 0, 5'd7, 8'h00);
        applyStimulus("tie1",  1, 1, 5'd7, 8'h11, 1, 1, 5'd7, 8'h22);
        applyStimulus("tie2",  0, 0, 5'd7, 8'h11, 1, 1, 5'd7, 8'h22);
        applyStimulus("rd7",   1, 0, 5'd7, 8'h00, 0, 0, 5'd0, 8'h00);
        checkOutput("rd7.final", 32'(bus.rdata), 32'h22);

        for (int k = 0; k < 4; k++) begin
            applyStimulus("cont", 1, 0, 5'(k), 8'h00, 1, 0, 5'(k + 8), 8'h00);
        end

        applyStimulus("bwr0",  0, 0, 5'd0, 8'h00, 1, 1, 5'd0,  8'h80);
        applyStimulus("bwr31", 0, 0, 5'd0, 8'h00, 1, 1, 5'd31, 8'h01);
        applyStimulus("brd0",  0, 0, 5'd0, 8'h00, 1, 0, 5'd0,  8'h00);
        checkOutput("brd0.val", 32'(bus.rdata), 32'h80);
        applyStimulus("brd31", 0, 0, 5'd0, 8'h00, 1, 0, 5'd31, 8'h00);
        checkOutput("brd31.val", 32'(bus.rdata), 32'h01);

        for (int n = 0; n < 40; n++) begin
            applyStimulus("rand",
                          1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom),
                          1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom));
        end

        // Reset lands in the ACCESS cycle of an A write.
        bus.req_a   = 1'b1;
        bus.we_a    = 1'b1;
        bus.addr_a  = 5'd31;
        bus.wdata_a = 8'hFF;
        bus.req_b   = 1'b0;
        @(posedge clk); #1;
        checkOutput("mid.gnt_a", 32'(bus.gnt_a), 32'(1));
        checkOutput("mid.wre_pre", 32'(bus.mem_wre), 32'(1));
        rst = 1'b1;
        bus.req_a = 1'b0;
        #1;
        checkOutput("mid.wre_gated", 32'(bus.mem_wre), 32'(0));
        checkOutput("mid.mem_ce", 32'(bus.mem_ce), 32'(0));
        @(posedge clk); #1;
        checkOutput("mid.rvalid", 32'({bus.rvalid_a, bus.rvalid_b}), 32'(0));
        checkOutput("mid.rdata", 32'(bus.rdata), 32'(0));
        rst = 1'b0;
        modelReset();
        applyStimulus("mid.rd31", 1, 0, 5'd31, 8'h00, 0, 0, 5'd0, 8'h00);
        checkOutput("mid.rd31.val", 32'(bus.rdata), 32'h00);

        idleInputs();
        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
